// File: rtl/drac_pkg.sv
// Shared commit-path types for the drac core.
// Commit record layout consumed by the commit logger.
package drac_pkg;

  localparam int unsigned COMMIT_WIDTH = 2;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        rd_we;
    logic [63:0] result;
  } commit_data_t;

endpackage

// File: rtl/commit_log_buffer_ring.sv
// Circular commit-record storage with two write ports and two adjacent read ports.
// Reads are combinational from the stored array; writes land on the rising edge.
module commit_ring_2w2r
  import drac_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                                 clk,
  input  logic         [COMMIT_WIDTH-1:0]      we_i,
  input  logic         [$clog2(DEPTH)-1:0]     wr_idx0_i,
  input  logic         [$clog2(DEPTH)-1:0]     wr_idx1_i,
  input  commit_data_t [COMMIT_WIDTH-1:0]      wr_data_i,
  input  logic         [$clog2(DEPTH)-1:0]     rd_ptr_i,
  output commit_data_t [COMMIT_WIDTH-1:0]      rd_data_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  commit_data_t    mem_q [DEPTH];
  logic [PtrW-1:0] rd_idx1;

  // The two write indices are always distinct, so both ports may fire together.
  always_ff @(posedge clk) begin
    if (we_i[0]) mem_q[wr_idx0_i] <= wr_data_i[0];
    if (we_i[1]) mem_q[wr_idx1_i] <= wr_data_i[1];
  end

  always_comb begin
    rd_idx1      = rd_ptr_i + PtrW'(1);
    rd_data_o[0] = mem_q[rd_ptr_i];
    rd_data_o[1] = mem_q[rd_idx1];
  end

endmodule

// File: rtl/commit_log_buffer.sv
// Elastic 2-in/2-out FIFO between the commit ports and the commit logger.
// Compacts sparse commit slots, drops the younger excess when full, and counts drops.
module commit_log_buffer
  import drac_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_MARGIN = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic         [COMMIT_WIDTH-1:0]    commit_valid_i,
  input  commit_data_t [COMMIT_WIDTH-1:0]    commit_data_i,
  input  logic                               drain_en_i,
  output logic         [COMMIT_WIDTH-1:0]    commit_valid_o,
  output commit_data_t [COMMIT_WIDTH-1:0]    commit_data_o,
  output logic                               full_o,
  output logic                               almost_full_o,
  output logic         [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic         [CNT_W-1:0]           drop_cnt_o
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned OccW  = $clog2(DEPTH + 1);
  localparam int unsigned FreeW = OccW + 1;
  localparam int unsigned SumW  = CNT_W + 1;

  localparam logic [FreeW-1:0] DepthF   = FreeW'(DEPTH);
  localparam logic [OccW-1:0]  DepthO   = OccW'(DEPTH);
  localparam logic [OccW-1:0]  AfThresh = OccW'(DEPTH - AF_MARGIN);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  logic [OccW-1:0]  occ_q, occ_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [SumW-1:0]  drop_sum;

  logic [COMMIT_WIDTH-1:0]  valid_q, valid_d;
  commit_data_t [COMMIT_WIDTH-1:0] data_q, data_d;

  logic [1:0]       n_push, n_pop, n_acc, n_drop;
  logic [FreeW-1:0] free;

  logic [COMMIT_WIDTH-1:0]         ring_we;
  logic [PtrW-1:0]                 wr_idx1;
  commit_data_t [COMMIT_WIDTH-1:0] ring_wr_data;
  commit_data_t [COMMIT_WIDTH-1:0] ring_rd_data;

  always_comb begin
    n_push = 2'(commit_valid_i[0]) + 2'(commit_valid_i[1]);

    if (!drain_en_i)              n_pop = 2'd0;
    else if (occ_q >= OccW'(2))   n_pop = 2'd2;
    else                          n_pop = occ_q[1:0];

    // Space freed by this cycle's pop is usable by this cycle's push.
    free = DepthF - FreeW'(occ_q) + FreeW'(n_pop);
    if (FreeW'(n_push) <= free) n_acc = n_push;
    else                        n_acc = free[1:0];
    n_drop = n_push - n_acc;

    // Compaction: the oldest valid slot always lands in the first write lane.
    ring_wr_data[0] = commit_valid_i[0] ? commit_data_i[0] : commit_data_i[1];
    ring_wr_data[1] = commit_data_i[1];
    ring_we[0]      = (n_acc != 2'd0);
    ring_we[1]      = (n_acc == 2'd2);
    wr_idx1         = wr_ptr_q + PtrW'(1);

    wr_ptr_d = wr_ptr_q + PtrW'(n_acc);
    rd_ptr_d = rd_ptr_q + PtrW'(n_pop);
    occ_d    = occ_q + OccW'(n_acc) - OccW'(n_pop);

    drop_sum   = {1'b0, drop_cnt_q} + SumW'(n_drop);
    drop_cnt_d = drop_sum[CNT_W] ? CntMax : drop_sum[CNT_W-1:0];

    unique case (n_pop)
      2'd2:    valid_d = 2'b11;
      2'd1:    valid_d = 2'b01;
      default: valid_d = 2'b00;
    endcase

    // Lanes not carrying a new entry keep their previous record.
    data_d = data_q;
    if (n_pop != 2'd0) data_d[0] = ring_rd_data[0];
    if (n_pop == 2'd2) data_d[1] = ring_rd_data[1];
  end

  commit_ring_2w2r #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk       (clk),
    .we_i      (ring_we),
    .wr_idx0_i (wr_ptr_q),
    .wr_idx1_i (wr_idx1),
    .wr_data_i (ring_wr_data),
    .rd_ptr_i  (rd_ptr_q),
    .rd_data_o (ring_rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      drop_cnt_q <= '0;
      valid_q    <= '0;
      data_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  assign commit_valid_o = valid_q;
  assign commit_data_o  = data_q;
  assign occupancy_o    = occ_q;
  assign full_o         = (occ_q == DepthO);
  assign almost_full_o  = (occ_q >= AfThresh);
  assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_commit_log_buffer.sv
// Directed bench for commit_log_buffer: a queue model of the FIFO feeds an output scoreboard.
module tb_commit_log_buffer;
  import drac_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned OccW  = $clog2(DEPTH + 1);

  logic                            clk;
  logic                            rst;
  logic         [1:0]              commit_valid_i;
  commit_data_t [1:0]              commit_data_i;
  logic                            drain_en_i;

  logic         [1:0]              valid_a, valid_b;
  commit_data_t [1:0]              data_a, data_b;
  logic                            full_a, full_b, af_a, af_b;
  logic         [OccW-1:0]         occ_a, occ_b;
  logic         [15:0]             drop_a;
  logic         [3:0]              drop_b;

  commit_log_buffer #(
    .DEPTH     (DEPTH),
    .AF_MARGIN (2),
    .CNT_W     (16)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .commit_valid_i (commit_valid_i),
    .commit_data_i  (commit_data_i),
    .drain_en_i     (drain_en_i),
    .commit_valid_o (valid_a),
    .commit_data_o  (data_a),
    .full_o         (full_a),
    .almost_full_o  (af_a),
    .occupancy_o    (occ_a),
    .drop_cnt_o     (drop_a)
  );

  commit_log_buffer #(
    .DEPTH     (DEPTH),
    .AF_MARGIN (2),
    .CNT_W     (4)
  ) u_dut4 (
    .clk            (clk),
    .rst            (rst),
    .commit_valid_i (commit_valid_i),
    .commit_data_i  (commit_data_i),
    .drain_en_i     (drain_en_i),
    .commit_valid_o (valid_b),
    .commit_data_o  (data_b),
    .full_o         (full_b),
    .almost_full_o  (af_b),
    .occupancy_o    (occ_b),
    .drop_cnt_o     (drop_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  commit_data_t mq[$];   // model FIFO contents
  commit_data_t sb[$];   // popped entries awaiting the output register
  int           drops;
  logic [1:0]   exp_valid;
  commit_data_t exp_d0, exp_d1;
  int           seq;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic commit_data_t mk(input int s);
    commit_data_t d;
    d.pc     = 64'h1000 + (64'(s) << 2);
    d.inst   = $urandom;
    d.rd     = 5'($urandom);
    d.rd_we  = 1'($urandom);
    d.result = {32'($urandom), 32'($urandom)};
    return d;
  endfunction

  function automatic commit_data_t rnd();
    return mk(int'($urandom_range(0, 1000)));
  endfunction

  task automatic model_reset();
    mq.delete();
    sb.delete();
    drops     = 0;
    exp_valid = 2'b00;
    exp_d0    = '0;
    exp_d1    = '0;
  endtask

  task automatic check_all(input string tag);
    int d16, d4;
    d16 = (drops > 65535) ? 65535 : drops;
    d4  = (drops > 15) ? 15 : drops;
    chk({tag, ".valid"},  256'(valid_a), 256'(exp_valid));
    chk({tag, ".data0"},  256'(data_a[0]), 256'(exp_d0));
    chk({tag, ".data1"},  256'(data_a[1]), 256'(exp_d1));
    chk({tag, ".occ"},    256'(occ_a), 256'(mq.size()));
    chk({tag, ".full"},   256'(full_a), 256'(mq.size() == DEPTH));
    chk({tag, ".afull"},  256'(af_a), 256'(mq.size() >= DEPTH - 2));
    chk({tag, ".drop16"}, 256'(drop_a), 256'(d16));
    chk({tag, ".drop4"},  256'(drop_b), 256'(d4));
    chk({tag, ".valid4"}, 256'(valid_b), 256'(exp_valid));
    chk({tag, ".occ4"},   256'(occ_b), 256'(mq.size()));
  endtask

  task automatic cycle(input string tag, input logic [1:0] v, input logic dr);
    int           n_pop;
    commit_data_t d0, d1;
    d0 = mk(seq);
    d1 = mk(seq + 1);
    seq += 2;
    commit_valid_i   = v;
    commit_data_i[0] = d0;
    commit_data_i[1] = d1;
    drain_en_i       = dr;
    n_pop = dr ? ((mq.size() >= 2) ? 2 : mq.size()) : 0;
    for (int k = 0; k < n_pop; k++) sb.push_back(mq.pop_front());
    if (v[0]) begin
      if (mq.size() < DEPTH) mq.push_back(d0); else drops++;
    end
    if (v[1]) begin
      if (mq.size() < DEPTH) mq.push_back(d1); else drops++;
    end
    @(posedge clk);
    #1;
    exp_valid = (n_pop == 2) ? 2'b11 : (n_pop == 1) ? 2'b01 : 2'b00;
    if (n_pop >= 1) exp_d0 = sb.pop_front();
    if (n_pop == 2) exp_d1 = sb.pop_front();
    check_all(tag);
  endtask

  task automatic cycle_pc(input string tag, input logic [1:0] v, input logic dr,
                          input logic [63:0] pc0, input logic [63:0] pc1);
    commit_data_t d0, d1;
    int           n_pop;
    d0 = rnd(); d0.pc = pc0;
    d1 = rnd(); d1.pc = pc1;
    commit_valid_i   = v;
    commit_data_i[0] = d0;
    commit_data_i[1] = d1;
    drain_en_i       = dr;
    n_pop = dr ? ((mq.size() >= 2) ? 2 : mq.size()) : 0;
    for (int k = 0; k < n_pop; k++) sb.push_back(mq.pop_front());
    if (v[0]) begin
      if (mq.size() < DEPTH) mq.push_back(d0); else drops++;
    end
    if (v[1]) begin
      if (mq.size() < DEPTH) mq.push_back(d1); else drops++;
    end
    @(posedge clk);
    #1;
    exp_valid = (n_pop == 2) ? 2'b11 : (n_pop == 1) ? 2'b01 : 2'b00;
    if (n_pop >= 1) exp_d0 = sb.pop_front();
    if (n_pop == 2) exp_d1 = sb.pop_front();
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, 256'(valid_a), 256'(0));
    chk({tag, ".data"},  256'(data_a), 256'(0));
    chk({tag, ".occ"},   256'(occ_a), 256'(0));
    chk({tag, ".full"},  256'(full_a), 256'(0));
    chk({tag, ".afull"}, 256'(af_a), 256'(0));
    chk({tag, ".drop"},  256'(drop_a), 256'(0));
    chk({tag, ".drop4"}, 256'(drop_b), 256'(0));
  endtask

  initial begin
    seq = 0;
    model_reset();

    // Reset held for 3 cycles with random inputs.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      commit_valid_i   = 2'($urandom);
      commit_data_i[0] = rnd();
      commit_data_i[1] = rnd();
      drain_en_i       = 1'($urandom);
      @(posedge clk);
    end
    #1;
    check_zero("reset");
    commit_valid_i = 2'b00;
    drain_en_i     = 1'b0;
    rst            = 1'b1;

    // Lone slot-1 commit reaches the logger two cycles later in lane 0.
    cycle_pc("lone", 2'b10, 1'b1, 64'h0, 64'h8000_0004);
    cycle("lone_w", 2'b00, 1'b1);
    chk("lone_valid", 256'(valid_a), 256'(2'b01));
    chk("lone_pc", 256'(data_a[0].pc), 256'(64'h8000_0004));
    cycle("lone_idle", 2'b00, 1'b1);
    chk("empty_drain_valid", 256'(valid_a), 256'(2'b00));

    // Fill to full with drain disabled, then overflow by two.
    for (int i = 0; i < 8; i++) begin
      cycle("fill", 2'b11, 1'b0);
      if (i == 5) chk("af_low_at12", 256'(af_a), 256'(0));
      if (i == 6) chk("af_at14", 256'(af_a), 256'(1));
      if (i == 6) chk("nfull_at14", 256'(full_a), 256'(0));
    end
    chk("full_at16", 256'(full_a), 256'(1));
    cycle("over", 2'b11, 1'b0);
    chk("over_drop", 256'(drop_a), 256'(2));
    chk("over_occ", 256'(occ_a), 256'(16));

    // Push and pop together while full: nothing dropped.
    cycle("full_pp", 2'b11, 1'b1);
    chk("full_pp_occ", 256'(occ_a), 256'(16));
    chk("full_pp_drop", 256'(drop_a), 256'(2));
    for (int i = 0; i < 9; i++) cycle("drain", 2'b00, 1'b1);

    // Walk the pointers to DEPTH-1 so A sits in the last slot and B, C wrap.
    for (int i = 0; i < 6; i++) cycle("walk_w", 2'b11, 1'b0);
    for (int i = 0; i < 7; i++) cycle("walk_r", 2'b00, 1'b1);
    cycle_pc("abc0", 2'b11, 1'b0, 64'hA, 64'hB);
    cycle_pc("abc1", 2'b01, 1'b0, 64'hC, 64'h0);
    cycle("abc_pop0", 2'b00, 1'b1);
    chk("abc_v0", 256'(valid_a), 256'(2'b11));
    chk("abc_a", 256'(data_a[0].pc), 256'(64'hA));
    chk("abc_b", 256'(data_a[1].pc), 256'(64'hB));
    cycle("abc_pop1", 2'b00, 1'b1);
    chk("abc_v1", 256'(valid_a), 256'(2'b01));
    chk("abc_c", 256'(data_a[0].pc), 256'(64'hC));
    cycle("abc_pop2", 2'b00, 1'b1);
    chk("abc_v2", 256'(valid_a), 256'(2'b00));

    // Saturate the narrow drop counter.
    for (int i = 0; i < 8; i++) cycle("refill", 2'b11, 1'b0);
    for (int i = 0; i < 9; i++) cycle("sat", 2'b11, 1'b0);
    chk("sat4", 256'(drop_b), 256'(15));
    chk("sat16", 256'(drop_a), 256'(20));

    // Reset mid-drain clears everything without waiting for an edge.
    cycle("mid0", 2'b11, 1'b1);
    cycle("mid1", 2'b01, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    commit_valid_i = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle("post_rst", 2'b00, 1'b1);
    chk("post_rst_valid", 256'(valid_a), 256'(2'b00));
    cycle_pc("post_rst_push", 2'b01, 1'b1, 64'h55, 64'h0);
    cycle("post_rst_out", 2'b00, 1'b1);
    chk("post_rst_pc", 256'(data_a[0].pc), 256'(64'h55));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
